// File: rtl/playbus_copier_if.sv
// PlayBus shared-bus signals seen by one initiator.
// master: the initiator drives strobes/data; slave: the bus fabric side.
interface playbus_copier_if;
    logic [3:0] data_in;
    logic [3:0] data_out;
    logic       data_oe;
    logic [2:0] address;
    logic       ROMO;
    logic       RAMO;
    logic       RAMW;
    logic       LEDLTCH;

    modport master (
        input  data_in,
        output data_out,
        output data_oe,
        output address,
        output ROMO,
        output RAMO,
        output RAMW,
        output LEDLTCH
    );

    modport slave (
        output data_in,
        input  data_out,
        input  data_oe,
        input  address,
        input  ROMO,
        input  RAMO,
        input  RAMW,
        input  LEDLTCH
    );
endinterface

// File: rtl/playbus_copier.sv
// PlayBus EPROM->RAM block copier with checksum written to the LED latch.
// Define PLAYBUS_VERIFY_EN to add a RAM read-back check after every write.
module playbus_copier (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [2:0]          src_base,
    input  logic [2:0]          dst_base,
    input  logic [3:0]          count,
    playbus_copier_if.master    bus,
    output logic                busy,
    output logic                done,
    output logic                error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_VF,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] i_q, i_d;
    logic [2:0] src_q, src_d;
    logic [2:0] dst_q, dst_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] hold_q, hold_d;
    logic [3:0] sum_q, sum_d;

    logic [3:0] data_out_q, data_out_d;
    logic       data_oe_q, data_oe_d;
    logic [2:0] address_q, address_d;
    logic       romo_q, romo_d;
    logic       ramo_q, ramo_d;
    logic       ramw_q, ramw_d;
    logic       ledltch_q, ledltch_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

`ifdef PLAYBUS_VERIFY_EN
    logic       err_q, err_d;
`endif

    // Next-state and operand/datapath updates.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        sum_d   = sum_q;
`ifdef PLAYBUS_VERIFY_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d   = src_base;
                    dst_d   = dst_base;
                    cnt_d   = count;
                    sum_d   = 4'h0;
                    i_d     = 4'h0;
`ifdef PLAYBUS_VERIFY_EN
                    err_d   = 1'b0;
`endif
                    state_d = (count == 4'h0) ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                hold_d  = bus.data_in;
                sum_d   = sum_q + bus.data_in;
                state_d = S_WR;
            end
            S_WR: begin
`ifdef PLAYBUS_VERIFY_EN
                state_d = S_VF;
`else
                i_d     = i_q + 4'd1;
                state_d = (i_q + 4'd1 == cnt_q) ? S_DONE : S_RD;
`endif
            end
`ifdef PLAYBUS_VERIFY_EN
            S_VF: begin
                if (bus.data_in != hold_q)
                    err_d = 1'b1;
                i_d     = i_q + 4'd1;
                state_d = (i_q + 4'd1 == cnt_q) ? S_DONE : S_RD;
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they land in the flops
    // together with it and stay glitch-free on the shared bus.
    always_comb begin
        data_out_d = 4'h0;
        data_oe_d  = 1'b0;
        address_d  = 3'h0;
        romo_d     = 1'b0;
        ramo_d     = 1'b0;
        ramw_d     = 1'b0;
        ledltch_d  = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state_d)
            S_RD: begin
                address_d = src_d + i_d[2:0];
                romo_d    = 1'b1;
                busy_d    = 1'b1;
            end
            S_WR: begin
                address_d  = dst_d + i_d[2:0];
                data_out_d = hold_d;
                data_oe_d  = 1'b1;
                ramw_d     = 1'b1;
                busy_d     = 1'b1;
            end
`ifdef PLAYBUS_VERIFY_EN
            S_VF: begin
                address_d = dst_d + i_d[2:0];
                ramo_d    = 1'b1;
                busy_d    = 1'b1;
            end
`endif
            S_DONE: begin
                data_out_d = sum_d;
                data_oe_d  = 1'b1;
                ledltch_d  = 1'b1;
                busy_d     = 1'b1;
                done_d     = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            i_q        <= 4'h0;
            src_q      <= 3'h0;
            dst_q      <= 3'h0;
            cnt_q      <= 4'h0;
            hold_q     <= 4'h0;
            sum_q      <= 4'h0;
            data_out_q <= 4'h0;
            data_oe_q  <= 1'b0;
            address_q  <= 3'h0;
            romo_q     <= 1'b0;
            ramo_q     <= 1'b0;
            ramw_q     <= 1'b0;
            ledltch_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            sum_q      <= sum_d;
            data_out_q <= data_out_d;
            data_oe_q  <= data_oe_d;
            address_q  <= address_d;
            romo_q     <= romo_d;
            ramo_q     <= ramo_d;
            ramw_q     <= ramw_d;
            ledltch_q  <= ledltch_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef PLAYBUS_VERIFY_EN
    always_ff @(posedge clk) begin
        if (reset)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end
    assign error = err_q;
`else
    assign error = 1'b0;
`endif

    assign bus.data_out = data_out_q;
    assign bus.data_oe  = data_oe_q;
    assign bus.address  = address_q;
    assign bus.ROMO     = romo_q;
    assign bus.RAMO     = ramo_q;
    assign bus.RAMW     = ramw_q;
    assign bus.LEDLTCH  = ledltch_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_playbus_copier.sv
// Directed bench for playbus_copier with an EPROM model ROM[a]=a+3
// and an 8-entry RAM on the shared bus.
module tb_playbus_copier;

`ifdef PLAYBUS_VERIFY_EN
    localparam int P = 3;
`else
    localparam int P = 2;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] src_base;
    logic [2:0] dst_base;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic       error;
    logic       corrupt;
    logic [3:0] bus_in;
    logic [3:0] ram [8];
    int         nwr = 0;
    int         n_assert = 0;
    int         n_fail = 0;
    int         cyc;
    int         nb;
    int         snap;

    playbus_copier_if bus ();

    playbus_copier dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_base (src_base),
        .dst_base (dst_base),
        .count    (count),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] rom(input logic [2:0] a);
        rom = {1'b0, a} + 4'd3;
    endfunction

    always_comb begin
        bus_in = 4'h0;
        if (bus.ROMO)
            bus_in = rom(bus.address);
        else if (bus.RAMO)
            bus_in = ram[bus.address] ^
                     ((corrupt && bus.address == 3'd5) ? 4'h1 : 4'h0);
        else if (bus.data_oe)
            bus_in = bus.data_out;
    end
    assign bus.data_in = bus_in;

    always @(posedge clk) begin
        if (bus.RAMW === 1'b1) begin
            ram[bus.address] <= bus.data_out;
            nwr <= nwr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("inv_onehot",
            32'($countones({bus.ROMO, bus.RAMO, bus.data_oe}) <= 1), 32'd1);
        chk("inv_ramw_oe", 32'(!bus.RAMW || bus.data_oe), 32'd1);
        chk("inv_led_oe", 32'(!bus.LEDLTCH || bus.data_oe), 32'd1);
    end

    task automatic go(input logic [2:0] s, input logic [2:0] d,
                      input logic [3:0] n);
        @(negedge clk);
        src_base = s;
        dst_base = d;
        count    = n;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(output int c, output int b);
        c = 0;
        b = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && c < 200) begin
            @(negedge clk);
            c++;
            b += (busy === 1'b1) ? 1 : 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        src_base = 3'd0;
        dst_base = 3'd0;
        count = 4'd0;
        corrupt = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_strobes", {bus.ROMO, bus.RAMO, bus.RAMW, bus.LEDLTCH,
                            bus.data_oe, busy, done, error}, 32'h0);
        chk("rst_addr_data", {bus.address, bus.data_out}, 32'h0);
        reset = 1'b0;

        go(3'd0, 3'd4, 4'd3);
        chk("basic_rd0", {bus.ROMO, bus.address, busy}, {1'b1, 3'd0, 1'b1});
        wait_done(cyc, nb);
        chk("basic_done_cyc", cyc, P * 3);
        chk("basic_busy_len", nb, P * 3 + 1);
        chk("basic_sum", bus.data_out, 32'hC);
        chk("basic_led", {bus.LEDLTCH, bus.data_oe}, 32'h3);
        chk("basic_ram", {ram[4], ram[5], ram[6]}, 32'h345);
        chk("basic_err", error, 32'h0);
        @(negedge clk);
        chk("basic_idle", {busy, done, bus.data_oe}, 32'h0);

        go(3'd6, 3'd7, 4'd3);
        wait_done(cyc, nb);
        chk("wrap_done_cyc", cyc, P * 3);
        chk("wrap_sum", bus.data_out, 32'h6);
        chk("wrap_ram", {ram[7], ram[0], ram[1]}, 32'h9A3);

        go(3'd3, 3'd3, 4'd0);
        chk("cnt0_done", {done, bus.ROMO, bus.RAMW, bus.data_oe,
                          bus.LEDLTCH}, 32'b10011);
        chk("cnt0_sum", bus.data_out, 32'h0);
        wait_done(cyc, nb);
        chk("cnt0_cyc", {cyc[7:0], nb[7:0]}, 32'h0001);
        @(negedge clk);
        chk("cnt0_idle", {busy, done, bus.ROMO, bus.RAMW}, 32'h0);

        go(3'd0, 3'd0, 4'd8);
        repeat (1 + 2 * P) @(negedge clk);
        chk("rst_mid_wr3", {bus.RAMW, bus.address}, {1'b1, 3'd2});
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_out", {bus.ROMO, bus.RAMO, bus.RAMW, bus.LEDLTCH,
                            bus.data_oe, busy, done, bus.address,
                            bus.data_out}, 32'h0);
        snap = nwr;
        repeat (3) @(negedge clk);
        chk("rst_mid_nowr", nwr, snap);
        chk("rst_mid_ram2", ram[2], 32'h5);
        reset = 1'b0;
        go(3'd1, 3'd3, 4'd2);
        wait_done(cyc, nb);
        chk("after_rst_cyc", cyc, P * 2);
        chk("after_rst_sum", bus.data_out, 32'h9);
        chk("after_rst_ram", {ram[3], ram[4]}, 32'h45);

        @(negedge clk);
        src_base = 3'd2;
        dst_base = 3'd0;
        count = 4'd2;
        start = 1'b1;
        @(negedge clk);
        chk("held_rd0", {bus.ROMO, bus.address}, {1'b1, 3'd2});
        src_base = 3'd4;
        dst_base = 3'd6;
        count = 4'd1;
        wait_done(cyc, nb);
        chk("held_done_cyc", cyc, P * 2);
        chk("held_sum", bus.data_out, 32'hB);
        chk("held_ram", {ram[0], ram[1]}, 32'h56);
        @(negedge clk);
        chk("held_idle", {busy, bus.ROMO, done}, 32'h0);
        @(negedge clk);
        chk("held_second", {bus.ROMO, bus.address, busy}, {1'b1, 3'd4, 1'b1});
        start = 1'b0;
        wait_done(cyc, nb);
        chk("held2_cyc", cyc, P);
        chk("held2_sum", bus.data_out, 32'h7);
        chk("held2_ram", ram[6], 32'h7);

`ifdef PLAYBUS_VERIFY_EN
        corrupt = 1'b1;
        go(3'd0, 3'd4, 4'd3);
        repeat (5) @(negedge clk);
        chk("vf_ram5", {bus.RAMO, bus.address, error}, {1'b1, 3'd5, 1'b0});
        @(negedge clk);
        chk("vf_err_set", error, 32'h1);
        wait_done(cyc, nb);
        chk("vf_done_cyc", cyc, 3);
        chk("vf_sum", {bus.data_out, error}, {4'hC, 1'b1});
        chk("vf_ram", {ram[4], ram[5], ram[6]}, 32'h345);
        corrupt = 1'b0;
        go(3'd0, 3'd4, 4'd1);
        chk("vf_err_clr", error, 32'h0);
        wait_done(cyc, nb);
        chk("vf2_cyc", {cyc[7:0], error}, {8'(P), 1'b0});
`else
        chk("noverify_err", error, 32'h0);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/playbus_copier.md
# playbus_copier

Autonomous bus initiator for the PlayBus 4-bit shared data bus. On a start pulse it copies a block of nibbles from EPROM to RAM. Each transfer has two phases: an EPROM read cycle into a holding register, then a RAM write cycle driving the bus from that register. It finishes by latching a 4-bit checksum into the LED latch. It sits alongside the switch-driven controller as a second bus initiator and drives the same strobes the responders already decode.

## Interface
- No parameters; widths are fixed by the PlayBus (4-bit data, 3-bit address).
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle request; sampled only in IDLE
- src_base  input  3  first EPROM address
- dst_base  input  3  first RAM address
- count  input  4  number of nibbles to copy, 0..15
- data_in  input  4  sampled value of the shared bus
- data_out  output  4  value this block drives onto the bus
- data_oe  output  1  enables data_out onto the bus (external tristate)
- address  output  3  bus address
- ROMO  output  1  EPROM output enable
- RAMO  output  1  RAM output enable
- RAMW  output  1  RAM write enable (RAM writes on the clk edge ending the cycle)
- LEDLTCH  output  1  LED latch load enable
- busy  output  1  high from first RD cycle through DONE cycle
- done  output  1  one-cycle pulse in DONE state
- error  output  1  sticky verify mismatch flag (see Configuration)

## Operation
- All outputs are registered. They are a Moore decode of state, index i, and hold register.
- Reset values: state=IDLE, i=0, hold=0, checksum=0, error=0, data_out=0, data_oe=0, address=0, ROMO=RAMO=RAMW=LEDLTCH=busy=done=0.
- IDLE: all strobes low.
  - start=1 latches src_base, dst_base, count, clears checksum/error/i.
  - Next state is RD, or DONE if count=0.
- RD: address=src+i, ROMO=1. At the closing edge, hold<=data_in and checksum<=checksum+data_in (mod 16). Next state is WR.
- WR: address=dst+i, data_out=hold, data_oe=1, RAMW=1. Next state is VF if compiled in; otherwise see the advance rule below.
- VF (VERIFY_EN only): address=dst+i, RAMO=1. At the closing edge, data_in≠hold sets error.
- Advance rule: i<=i+1. If i+1=count, next state is DONE; else next state is RD.
- DONE: data_out=checksum, data_oe=1, LEDLTCH=1, done=1, busy=1. Next state is IDLE.
- Address arithmetic: src+i and dst+i are 3-bit, wrapping mod 8. Counts above 8 revisit addresses.
- Overlap: processing is strictly sequential, so a later read observes an earlier write.
- Bus-safety invariants:
  - At most one of ROMO, RAMO, data_oe is high in any cycle.
  - RAMW=1 implies data_oe=1.
  - LEDLTCH=1 implies data_oe=1.
- start while busy: ignored, with no effect on latched operands.
- reset in any state: at the next edge all outputs return to reset values. No partial write follows, since RAMW is low from that cycle.

## Timing
- start sampled high in IDLE at edge k: first RD occupies cycle k+1.
- Cycles per nibble: P=2 without VERIFY_EN, P=3 with it.
- count=n>0: DONE occupies cycle k+1+P·n; busy is high for P·n+1 cycles; IDLE resumes at k+2+P·n.
- count=0: DONE in cycle k+1, checksum 0.
- A new start is accepted in the first IDLE cycle after DONE.

## Configuration
- PLAYBUS_VERIFY_EN defined:
  - VF read-back state is inserted after every WR.
  - error is set on any mismatch and held until the next accepted start or reset.
  - Copying continues after a mismatch.
- Not defined: no VF state, P=2, error tied to 0.

## Test plan
- Bench models ROM[a]=a+3 mod 16 and an 8-entry RAM.
- Basic copy: src=0, dst=4, count=3 → RAM[4..6]=3,4,5. DONE drives 0xC with LEDLTCH. done pulses at k+7 (P=2) or k+10 (P=3).
- Wrap: src=6, dst=7, count=3 → reads ROM 6,7,0; writes RAM 7,0,1 = 9,10,3; checksum 0x6.
- count=0: start → DONE next cycle, data_out=0, no ROMO/RAMW asserted.
- Reset mid-op: src=0, dst=0, count=8; assert reset during the 3rd WR cycle → all strobes 0 at the next edge, RAM[2] not rewritten afterwards, busy=0, a subsequent start works normally.
- start held high through a whole copy → exactly one transfer; a second begins only after IDLE is reached.
- With PLAYBUS_VERIFY_EN, a bench that corrupts the RAM[5] read-back → error=1 after that VF, copy completes, error cleared by the next start.
- Every test asserts the bus-safety invariants each cycle.
